// File: rtl/regfile_writeback.sv
// regfile_writeback: arbitrates ALU/load results into an in-order FIFO and drives one register-file write per cycle
module regfile_writeback #(
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_valid,
   output logic        alu_ready,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [4:0]  ld_rd,
   input  logic [31:0] ld_data,
   output logic        we,
   output logic [4:0]  wr,
   output logic [31:0] wd,
   output logic [31:0] pend_mask,
   output logic        idle
);
   logic [4:0]       q_rd   [DEPTH];
   logic [31:0]      q_data [DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [PTR_W:0]   count;
   logic             full, take_ld, take_alu, push, pop;
   logic [4:0]       in_rd;
   logic [31:0]      in_data, pend;
   assign full      = count == (PTR_W+1)'(DEPTH);
   assign ld_ready  = !full;
   assign alu_ready = !full && !ld_valid;
   assign take_ld   = ld_valid && ld_ready;
   assign take_alu  = alu_valid && alu_ready;
   assign in_rd     = take_ld ? ld_rd : alu_rd;
   assign in_data   = take_ld ? ld_data : alu_data;
   // writes to x0 finish their handshake but never enter the queue
   assign push      = (take_ld || take_alu) && in_rd != 5'd0;
   assign pop       = count != '0;
   assign idle      = count == '0 && !we;
   always_ff @(posedge clk) begin
      if (push) begin
         q_rd[wr_ptr]   <= in_rd;
         q_data[wr_ptr] <= in_data;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         we     <= 1'b0;
         wr     <= 5'd0;
         wd     <= 32'd0;
      end else begin
         wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
         rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
         count  <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
         we     <= pop;
         wr     <= pop ? q_rd[rd_ptr] : wr;
         wd     <= pop ? q_data[rd_ptr] : wd;
      end
   end
   always_comb begin
      pend = we ? 32'(1) << wr : 32'd0;
      for (int i = 0; i < DEPTH; i++)
         pend = (PTR_W+1)'(i) < count ? pend | (32'(1) << q_rd[rd_ptr + PTR_W'(i)]) : pend;
   end
   assign pend_mask = pend & 32'hFFFF_FFFE;
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: table-driven directed vectors with hand-computed expectations
module tb_regfile_writeback;
   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid, alu_ready, ld_valid, ld_ready, we, idle;
   logic [4:0]  alu_rd, ld_rd, wr;
   logic [31:0] alu_data, ld_data, wd, pend_mask;
   int          checks = 0;
   int          failures = 0;

   typedef struct {
      logic        rst;
      logic        av;
      logic [4:0]  ard;
      logic [31:0] adata;
      logic        lv;
      logic [4:0]  lrd;
      logic [31:0] ldata;
      logic        e_ar;
      logic        e_lr;
      logic        e_we;
      logic [4:0]  e_wr;
      logic [31:0] e_wd;
      logic [31:0] e_pm;
      logic        e_idle;
   } vec_t;

   localparam int N = 26;
   vec_t v [N];

   regfile_writeback dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
      .we(we), .wr(wr), .wd(wd), .pend_mask(pend_mask), .idle(idle)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, act, exp);
      end
   endtask

   initial begin
      // rst, av, ard, adata, lv, lrd, ldata | ar, lr | we, wr, wd, pend_mask, idle
      v[0]  = '{1, 0, 0, 0,            0, 0, 0,            1, 1, 0, 0,  0,            32'h0,    1};
      v[1]  = '{1, 1, 5, 32'hAA,       0, 0, 0,            1, 1, 0, 0,  0,            32'h20,   0};
      v[2]  = '{1, 0, 0, 0,            0, 0, 0,            1, 1, 1, 5,  32'hAA,       32'h20,   0};
      v[3]  = '{1, 0, 0, 0,            0, 0, 0,            1, 1, 0, 5,  32'hAA,       32'h0,    1};
      v[4]  = '{1, 1, 4, 32'h22222222, 1, 3, 32'h11111111, 0, 1, 0, 5,  32'hAA,       32'h08,   0};
      v[5]  = '{1, 1, 4, 32'h22222222, 0, 0, 0,            1, 1, 1, 3,  32'h11111111, 32'h18,   0};
      v[6]  = '{1, 0, 0, 0,            0, 0, 0,            1, 1, 1, 4,  32'h22222222, 32'h10,   0};
      v[7]  = '{1, 0, 0, 0,            0, 0, 0,            1, 1, 0, 4,  32'h22222222, 32'h0,    1};
      v[8]  = '{1, 1, 0, 32'hDEADBEEF, 0, 0, 0,            1, 1, 0, 4,  32'h22222222, 32'h0,    1};
      v[9]  = '{1, 0, 0, 0,            0, 0, 0,            1, 1, 0, 4,  32'h22222222, 32'h0,    1};
      v[10] = '{1, 0, 0, 0,            0, 0, 0,            1, 1, 0, 4,  32'h22222222, 32'h0,    1};
      v[11] = '{1, 0, 0, 0,            0, 0, 0,            1, 1, 0, 4,  32'h22222222, 32'h0,    1};
      v[12] = '{1, 1, 7, 32'h1,        0, 0, 0,            1, 1, 0, 4,  32'h22222222, 32'h80,   0};
      v[13] = '{1, 1, 7, 32'h2,        0, 0, 0,            1, 1, 1, 7,  32'h1,        32'h80,   0};
      v[14] = '{1, 1, 7, 32'h3,        0, 0, 0,            1, 1, 1, 7,  32'h2,        32'h80,   0};
      v[15] = '{1, 0, 0, 0,            0, 0, 0,            1, 1, 1, 7,  32'h3,        32'h80,   0};
      v[16] = '{1, 0, 0, 0,            0, 0, 0,            1, 1, 0, 7,  32'h3,        32'h0,    1};
      v[17] = '{1, 1, 9, 32'h99,       1, 0, 32'h5,        0, 1, 0, 7,  32'h3,        32'h0,    1};
      v[18] = '{1, 1, 9, 32'h99,       0, 0, 0,            1, 1, 0, 7,  32'h3,        32'h200,  0};
      v[19] = '{1, 0, 0, 0,            0, 0, 0,            1, 1, 1, 9,  32'h99,       32'h200,  0};
      v[20] = '{1, 1, 10, 32'hA,       0, 0, 0,            1, 1, 0, 9,  32'h99,       32'h400,  0};
      v[21] = '{1, 1, 11, 32'hB,       0, 0, 0,            1, 1, 1, 10, 32'hA,        32'hC00,  0};
      v[22] = '{1, 1, 12, 32'hC,       0, 0, 0,            1, 1, 1, 11, 32'hB,        32'h1800, 0};
      v[23] = '{0, 1, 13, 32'hD,       0, 0, 0,            1, 1, 0, 0,  0,            32'h0,    1};
      v[24] = '{1, 0, 0, 0,            0, 0, 0,            1, 1, 0, 0,  0,            32'h0,    1};
      v[25] = '{1, 0, 0, 0,            0, 0, 0,            1, 1, 0, 0,  0,            32'h0,    1};
      rst = 1'b0;
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_we", 32'(we), 32'd0);
      chk("rst_wr", 32'(wr), 32'd0);
      chk("rst_wd", wd, 32'd0);
      chk("rst_pend", pend_mask, 32'd0);
      chk("rst_idle", 32'(idle), 32'd1);
      chk("rst_ld_ready", 32'(ld_ready), 32'd1);
      chk("rst_alu_ready", 32'(alu_ready), 32'd1);
      ld_valid = 1'b1;
      #1;
      chk("rst_alu_ready_ldv", 32'(alu_ready), 32'd0);
      ld_valid = 1'b0;
      for (int i = 0; i < N; i++) begin
         rst = v[i].rst;
         alu_valid = v[i].av; alu_rd = v[i].ard; alu_data = v[i].adata;
         ld_valid = v[i].lv; ld_rd = v[i].lrd; ld_data = v[i].ldata;
         #1;
         chk($sformatf("v%0d_alu_ready", i), 32'(alu_ready), 32'(v[i].e_ar));
         chk($sformatf("v%0d_ld_ready", i), 32'(ld_ready), 32'(v[i].e_lr));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_we", i), 32'(we), 32'(v[i].e_we));
         chk($sformatf("v%0d_wr", i), 32'(wr), 32'(v[i].e_wr));
         chk($sformatf("v%0d_wd", i), wd, v[i].e_wd);
         chk($sformatf("v%0d_pend", i), pend_mask, v[i].e_pm);
         chk($sformatf("v%0d_idle", i), 32'(idle), 32'(v[i].e_idle));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
